// File: rtl/ll_req_arbiter_pkg.sv
// Shared types for the linked-list request path: opcode/specifier enums,
// field widths and the arbiter state encoding.
package ll_req_arbiter_pkg;

  localparam int HEADPTR_ADDR_WIDTH = 4;
  localparam int NODENUM_WIDTH      = 8;
  localparam int DATA_WIDTH         = 8;

  typedef enum logic [2:0] {
    NOP          = 3'd0,
    INSERT       = 3'd1,
    DELETE       = 3'd2,
    READ         = 3'd3,
    UPDATE       = 3'd4,
    CONFIG_HDPTR = 3'd5
  } t_mainop_types;

  // Encodings 4..7 are left undefined; the decoder reports them as errors.
  typedef enum logic [2:0] {
    SPEC_NONE = 3'd0,
    AT_HEAD   = 3'd1,
    AT_TAIL   = 3'd2,
    AT_POS    = 3'd3
  } t_specifier_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } t_ll_arb_st;

endpackage

// File: rtl/ll_req_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after the pointer,
// wrapping from NUM_REQ-1 back to 0. Purely combinational.
module ll_rr_pick
  import ll_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [REQ_IDX_W-1:0] i_ptr,
  output logic                 o_found,
  output logic [REQ_IDX_W-1:0] o_idx
);

  int w_pos;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (!o_found && i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = REQ_IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/ll_req_arbiter.sv
// Round-robin arbiter and request holder in front of ll_op_decode_unit.
// Define LL_ARB_WDOG_EN to abort requests that never complete (rq_err=1).
//
//   state | meaning
//   IDLE  | waiting for any rq_vld; captures the picked request
//   ISSUE | dec_req_vld high until the decoder and list manager accept
//   BUSY  | decoder working on held fields; waits for completion/error
module ll_req_arbiter
  import ll_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int REQ_IDX_W   = $clog2(NUM_REQ),
  parameter int WDOG_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            rq_vld,
  input  t_mainop_types                 rq_main_op [NUM_REQ],
  input  t_specifier_types              rq_spec    [NUM_REQ],
  input  logic [HEADPTR_ADDR_WIDTH-1:0] rq_ll_num  [NUM_REQ],
  input  logic [NODENUM_WIDTH-1:0]      rq_pos     [NUM_REQ],
  input  logic [DATA_WIDTH-1:0]         rq_data    [NUM_REQ],
  output logic [NUM_REQ-1:0]            rq_accept,
  output logic [NUM_REQ-1:0]            rq_done,
  output logic                          rq_err,
  output logic                          dec_req_vld,
  output t_mainop_types                 dec_main_op,
  output t_specifier_types              dec_spec,
  output logic [HEADPTR_ADDR_WIDTH-1:0] dec_ll_num,
  output logic [NODENUM_WIDTH-1:0]      dec_pos,
  output logic [DATA_WIDTH-1:0]         dec_data,
  input  logic                          dec_intf_ready,
  input  logic                          ll_mngr_fsm_idle,
  input  logic                          resp_gen_cmpltd,
  input  logic                          resp_gen_decode_err,
  output logic                          arb_busy,
  output logic [REQ_IDX_W-1:0]          arb_grant_idx
);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_chk_num_req
    $error("ll_req_arbiter: NUM_REQ must be in 2..16");
  end
  if (WDOG_CYCLES < 1) begin : g_chk_wdog
    $error("ll_req_arbiter: WDOG_CYCLES must be at least 1");
  end

  t_ll_arb_st                    r_state;
  logic [REQ_IDX_W-1:0]          r_rr_ptr;
  logic [REQ_IDX_W-1:0]          r_grant_idx;
  t_mainop_types                 r_main_op;
  t_specifier_types              r_spec;
  logic [HEADPTR_ADDR_WIDTH-1:0] r_ll_num;
  logic [NODENUM_WIDTH-1:0]      r_pos;
  logic [DATA_WIDTH-1:0]         r_data;
  logic [NUM_REQ-1:0]            r_accept;
  logic [NUM_REQ-1:0]            r_done;
  logic                          r_err;

  logic                          w_found;
  logic [REQ_IDX_W-1:0]          w_pick_idx;
  logic [REQ_IDX_W-1:0]          w_next_ptr;
  logic                          w_cmpl;
  logic                          w_wdog_exp;
  logic                          w_finish;
  logic                          w_finish_err;
  logic                          w_handoff;

  ll_rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_pick (
    .i_req   (rq_vld),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  // Completion inputs only count in BUSY; a simultaneous error wins.
  assign w_cmpl       = (r_state == BUSY) && (resp_gen_cmpltd || resp_gen_decode_err);
  assign w_finish     = w_cmpl || w_wdog_exp;
  assign w_finish_err = w_cmpl ? resp_gen_decode_err : 1'b1;
  assign w_handoff    = dec_intf_ready && ll_mngr_fsm_idle;
  assign w_next_ptr   = (r_grant_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : r_grant_idx + REQ_IDX_W'(1);

`ifdef LL_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic [WDOG_W-1:0] w_wdog_nxt;

  // Expiry fires on the edge where the count reaches WDOG_CYCLES.
  assign w_wdog_nxt = r_wdog_cnt + WDOG_W'(1);
  assign w_wdog_exp = (r_state != IDLE) && (w_wdog_nxt == WDOG_W'(WDOG_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_wdog_cnt <= '0;
    end else begin
      r_wdog_cnt <= w_wdog_nxt;
    end
  end
`else
  assign w_wdog_exp = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_main_op   <= NOP;
      r_spec      <= SPEC_NONE;
      r_ll_num    <= '0;
      r_pos       <= '0;
      r_data      <= '0;
      r_accept    <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_accept <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      if (w_finish) begin
        r_done   <= NUM_REQ'(1) << r_grant_idx;
        r_err    <= w_finish_err;
        r_rr_ptr <= w_next_ptr;
        r_state  <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_found) begin
              r_grant_idx <= w_pick_idx;
              r_main_op   <= rq_main_op[w_pick_idx];
              r_spec      <= rq_spec[w_pick_idx];
              r_ll_num    <= rq_ll_num[w_pick_idx];
              r_pos       <= rq_pos[w_pick_idx];
              r_data      <= rq_data[w_pick_idx];
              r_accept    <= NUM_REQ'(1) << w_pick_idx;
              r_state     <= ISSUE;
            end
          end
          ISSUE: begin
            if (w_handoff) r_state <= BUSY;
          end
          BUSY: begin
            r_state <= BUSY;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign rq_accept     = r_accept;
  assign rq_done       = r_done;
  assign rq_err        = r_err;
  assign dec_req_vld   = (r_state == ISSUE);
  assign arb_busy      = (r_state != IDLE);
  assign arb_grant_idx = r_grant_idx;
  assign dec_main_op   = r_main_op;
  assign dec_spec      = r_spec;
  assign dec_ll_num    = r_ll_num;
  assign dec_pos       = r_pos;
  assign dec_data      = r_data;

endmodule

// File: tb/tb_ll_req_arbiter.sv
// Directed scoreboard bench for ll_req_arbiter; the watchdog step runs only
// when LL_ARB_WDOG_EN is defined.
module tb_ll_req_arbiter;
  import ll_req_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int IW   = 2;
`ifdef LL_ARB_WDOG_EN
  localparam int BP_CYCLES = 8;
`else
  localparam int BP_CYCLES = 20;
`endif

  logic                          clk;
  logic                          reset_n;
  logic [NREQ-1:0]               rq_vld;
  t_mainop_types                 rq_main_op [NREQ];
  t_specifier_types              rq_spec    [NREQ];
  logic [HEADPTR_ADDR_WIDTH-1:0] rq_ll_num  [NREQ];
  logic [NODENUM_WIDTH-1:0]      rq_pos     [NREQ];
  logic [DATA_WIDTH-1:0]         rq_data    [NREQ];
  logic [NREQ-1:0]               rq_accept;
  logic [NREQ-1:0]               rq_done;
  logic                          rq_err;
  logic                          dec_req_vld;
  t_mainop_types                 dec_main_op;
  t_specifier_types              dec_spec;
  logic [HEADPTR_ADDR_WIDTH-1:0] dec_ll_num;
  logic [NODENUM_WIDTH-1:0]      dec_pos;
  logic [DATA_WIDTH-1:0]         dec_data;
  logic                          dec_intf_ready;
  logic                          ll_mngr_fsm_idle;
  logic                          resp_gen_cmpltd;
  logic                          resp_gen_decode_err;
  logic                          arb_busy;
  logic [IW-1:0]                 arb_grant_idx;

  ll_req_arbiter #(
    .NUM_REQ     (NREQ),
    .REQ_IDX_W   (IW),
    .WDOG_CYCLES (15)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .rq_vld              (rq_vld),
    .rq_main_op          (rq_main_op),
    .rq_spec             (rq_spec),
    .rq_ll_num           (rq_ll_num),
    .rq_pos              (rq_pos),
    .rq_data             (rq_data),
    .rq_accept           (rq_accept),
    .rq_done             (rq_done),
    .rq_err              (rq_err),
    .dec_req_vld         (dec_req_vld),
    .dec_main_op         (dec_main_op),
    .dec_spec            (dec_spec),
    .dec_ll_num          (dec_ll_num),
    .dec_pos             (dec_pos),
    .dec_data            (dec_data),
    .dec_intf_ready      (dec_intf_ready),
    .ll_mngr_fsm_idle    (ll_mngr_fsm_idle),
    .resp_gen_cmpltd     (resp_gen_cmpltd),
    .resp_gen_decode_err (resp_gen_decode_err),
    .arb_busy            (arb_busy),
    .arb_grant_idx       (arb_grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                            idx;
    t_mainop_types                 op;
    t_specifier_types              sp;
    logic [HEADPTR_ADDR_WIDTH-1:0] ll;
    logic [NODENUM_WIDTH-1:0]      pos;
    logic [DATA_WIDTH-1:0]         data;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input t_mainop_types op, input t_specifier_types sp,
                         input logic [3:0] ll, input logic [7:0] pos, input logic [7:0] data);
    rq_main_op[i] = op;
    rq_spec[i]    = sp;
    rq_ll_num[i]  = ll;
    rq_pos[i]     = pos;
    rq_data[i]    = data;
  endtask

  task automatic push_exp(input int i);
    exp_q.push_back('{i, rq_main_op[i], rq_spec[i], rq_ll_num[i], rq_pos[i], rq_data[i]});
  endtask

  task automatic wait_accept(input string tag, output int cyc);
    cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      cyc++;
      if (rq_accept != '0) break;
    end
    chk({tag, "_accept_seen"}, 32'(rq_accept != '0), 32'(1));
  endtask

  task automatic check_accept(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, "_accept"}, 32'(rq_accept), 32'(1) << e.idx);
    chk({tag, "_grant"},  32'(arb_grant_idx), 32'(e.idx));
    chk({tag, "_op"},     32'(dec_main_op), 32'(e.op));
    chk({tag, "_spec"},   32'(dec_spec), 32'(e.sp));
    chk({tag, "_llnum"},  32'(dec_ll_num), 32'(e.ll));
    chk({tag, "_pos"},    32'(dec_pos), 32'(e.pos));
    chk({tag, "_data"},   32'(dec_data), 32'(e.data));
    chk({tag, "_vld"},    32'(dec_req_vld), 32'(1));
    done_q.push_back(e.idx);
  endtask

  task automatic do_complete(input string tag, input logic cm, input logic de, input logic exp_err);
    int i;
    resp_gen_cmpltd     = cm;
    resp_gen_decode_err = de;
    @(negedge clk);
    resp_gen_cmpltd     = 1'b0;
    resp_gen_decode_err = 1'b0;
    i = done_q.pop_front();
    chk({tag, "_done"},      32'(rq_done), 32'(1) << i);
    chk({tag, "_err"},       32'(rq_err), 32'(exp_err));
    chk({tag, "_idle"},      32'(arb_busy), 32'(0));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"},   32'(arb_busy), 32'(0));
    chk({tag, "_vld"},    32'(dec_req_vld), 32'(0));
    chk({tag, "_accept"}, 32'(rq_accept), 32'(0));
    chk({tag, "_done"},   32'(rq_done), 32'(0));
    chk({tag, "_err"},    32'(rq_err), 32'(0));
    chk({tag, "_grant"},  32'(arb_grant_idx), 32'(0));
    chk({tag, "_op"},     32'(dec_main_op), 32'(0));
    chk({tag, "_spec"},   32'(dec_spec), 32'(0));
    chk({tag, "_data"},   32'(dec_data), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int prev;
    reset_n             = 1'b0;
    rq_vld              = '0;
    dec_intf_ready      = 1'b0;
    ll_mngr_fsm_idle    = 1'b0;
    resp_gen_cmpltd     = 1'b0;
    resp_gen_decode_err = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, NOP, SPEC_NONE, '0, '0, '0);

    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset_n = 1'b1;

    // single requester, field hold after accept
    dec_intf_ready   = 1'b1;
    ll_mngr_fsm_idle = 1'b1;
    set_req(0, INSERT, AT_HEAD, 4'd2, 8'd3, 8'hA5);
    rq_vld = 4'b0001;
    push_exp(0);
    wait_accept("single", cyc);
    chk("single_latency", 32'(cyc), 32'(1));
    check_accept("single");
    rq_vld     = '0;
    rq_data[0] = 8'hFF;
    @(negedge clk);
    chk("handoff_vld",  32'(dec_req_vld), 32'(0));
    chk("handoff_busy", 32'(arb_busy), 32'(1));
    repeat (3) @(negedge clk);
    chk("hold_data", 32'(dec_data), 32'hA5);
    do_complete("single", 1'b1, 1'b0, 1'b0);
    chk("hold_data_done", 32'(dec_data), 32'hA5);
    @(negedge clk);
    chk("done_pulse_1cyc", 32'(rq_done), 32'(0));

    // fairness from a fresh pointer
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_req(0, INSERT, AT_TAIL, 4'd4, 8'h20, 8'h30);
    set_req(1, DELETE, AT_TAIL, 4'd5, 8'h21, 8'h31);
    set_req(2, READ,   AT_TAIL, 4'd6, 8'h22, 8'h32);
    set_req(3, UPDATE, AT_POS,  4'd7, 8'h23, 8'h33);
    rq_vld = 4'b1111;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    prev = -1;
    for (int g = 0; g < 5; g++) begin
      wait_accept("fair", cyc);
      chk("fair_gap", 32'(cyc), 32'(1));
      chk("fair_no_repeat", 32'(int'(arb_grant_idx) != prev), 32'(1));
      prev = int'(arb_grant_idx);
      check_accept("fair");
      @(negedge clk);
      do_complete("fair", 1'b1, 1'b0, 1'b0);
    end
    rq_vld = '0;

    // back-pressure, then decode error on requester 2
    ll_mngr_fsm_idle = 1'b0;
    set_req(2, CONFIG_HDPTR, t_specifier_types'(3'd7), 4'd1, 8'd0, 8'h5C);
    rq_vld = 4'b0100;
    push_exp(2);
    wait_accept("bp", cyc);
    check_accept("bp");
    rq_vld = '0;
    for (int i = 0; i < BP_CYCLES; i++) begin
      @(negedge clk);
      chk("bp_vld",  32'(dec_req_vld), 32'(1));
      chk("bp_done", 32'(rq_done), 32'(0));
      resp_gen_cmpltd = (i == 4);
    end
    resp_gen_cmpltd  = 1'b0;
    ll_mngr_fsm_idle = 1'b1;
    @(negedge clk);
    chk("bp_to_busy_vld",  32'(dec_req_vld), 32'(0));
    chk("bp_to_busy_busy", 32'(arb_busy), 32'(1));
    do_complete("decerr", 1'b0, 1'b1, 1'b1);

    // next grant follows the errored index; simultaneous inputs mean error
    rq_vld = 4'b1111;
    push_exp(3);
    wait_accept("after_err", cyc);
    check_accept("after_err");
    @(negedge clk);
    do_complete("both", 1'b1, 1'b1, 1'b1);
    push_exp(0);
    wait_accept("wrap", cyc);
    chk("wrap_gap", 32'(cyc), 32'(1));
    check_accept("wrap");
    @(negedge clk);
    rq_vld = '0;

    // reset while BUSY
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_quiet("midrst");
    done_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(rq_done), 32'(0));
    end

`ifdef LL_ARB_WDOG_EN
    set_req(1, READ, AT_HEAD, 4'd9, 8'h44, 8'h66);
    rq_vld = 4'b0010;
    push_exp(1);
    wait_accept("wdog", cyc);
    check_accept("wdog");
    rq_vld = '0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (rq_done != '0) break;
    end
    chk("wdog_cycles", 32'(cyc), 32'(15));
    chk("wdog_done",   32'(rq_done), 32'(1) << done_q.pop_front());
    chk("wdog_err",    32'(rq_err), 32'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ll_req_arbiter.md
# ll_req_arbiter

Round-robin arbiter and request holder that lets NUM_REQ independent requesters share the single request port of the linked-list op decode unit. It captures one request at a time and presents it to the decoder. It holds every request field stable until the decoder signals completion or a decode error, then reports completion to the originating requester. It sits between the top-level request sources and `ll_op_decode_unit`.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- REQ_IDX_W, $clog2(NUM_REQ): width of the requester index.
- WDOG_CYCLES, 1023: watchdog limit in cycles. Used only when LL_ARB_WDOG_EN is defined.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- rq_vld  in  NUM_REQ  per-requester request valid.
- rq_main_op  in  NUM_REQ x t_mainop_types  per-requester main opcode.
- rq_spec  in  NUM_REQ x t_specifier_types  per-requester specifier.
- rq_ll_num  in  NUM_REQ x HEADPTR_ADDR_WIDTH  per-requester list number.
- rq_pos  in  NUM_REQ x NODENUM_WIDTH  per-requester node position.
- rq_data  in  NUM_REQ x DATA_WIDTH  per-requester data.
- rq_accept  out  NUM_REQ  one-hot, 1-cycle pulse when the request is captured.
- rq_done  out  NUM_REQ  one-hot, 1-cycle pulse when the request finishes.
- rq_err  out  1  qualifies rq_done; high when the request ended in error.
- dec_req_vld  out  1  request valid to the decoder.
- dec_main_op, dec_spec, dec_ll_num, dec_pos, dec_data  out  field widths as above  held request fields.
- dec_intf_ready  in  1  decoder is in IDLE.
- ll_mngr_fsm_idle  in  1  list manager is idle.
- resp_gen_cmpltd  in  1  response generation complete.
- resp_gen_decode_err  in  1  decoder rejected the request.
- arb_busy  out  1  high when the state is not IDLE.
- arb_grant_idx  out  REQ_IDX_W  index of the requester currently held.

## Operation
- FSM states: IDLE, ISSUE, BUSY.
- IDLE:
  - If any rq_vld is high, select the first requester at or after rr_ptr, scanning upward and wrapping from NUM_REQ-1 to 0.
  - Latch that requester's five fields into hold registers and latch its index into arb_grant_idx.
  - Pulse rq_accept[idx] and go to ISSUE.
  - If no rq_vld is high, stay in IDLE.
- ISSUE:
  - dec_req_vld=1.
  - When dec_intf_ready & ll_mngr_fsm_idle, go to BUSY. This is the same condition the decoder uses to accept a request.
- BUSY:
  - dec_req_vld=0. The dec_* fields stay held, because the decoder reads the fields during its forwarding states.
  - On resp_gen_decode_err or resp_gen_cmpltd:
    - Pulse rq_done[idx]. Set rq_err=resp_gen_decode_err.
    - Set rr_ptr = (idx==NUM_REQ-1) ? 0 : idx+1.
    - Go to IDLE.
- Fields are captured only in the IDLE capture cycle. Changes on rq_* after rq_accept are ignored.
- A requester may hold rq_vld across rq_done to issue another request. Round-robin still grants the other pending requesters first.
- dec_* fields are driven only from the hold registers. They never pass through combinationally from rq_*.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0, arb_grant_idx=0.
  - All hold registers 0, so dec_main_op=0 and dec_spec=0.
  - rq_accept, rq_done, rq_err, dec_req_vld and arb_busy all 0.
- Capture takes 1 cycle: rq_vld is sampled in IDLE at edge N; rq_accept and dec_req_vld are high during cycle N+1.
- Hand-off takes 0 cycles: the arbiter leaves ISSUE on the same edge at which the decoder leaves IDLE.
- Completion: rq_done pulses in the cycle after the resp_gen_cmpltd or resp_gen_decode_err cycle. The state is IDLE in that same cycle.
- Back-to-back: the minimum gap from rq_done to the next rq_accept is 1 cycle.
- If resp_gen_cmpltd and resp_gen_decode_err are high in the same cycle, treat it as an error: rq_err=1.
- Completion inputs are ignored in IDLE and ISSUE.
- If reset is asserted mid-request, all state clears immediately and no rq_done is issued. Requesters must re-issue.

## Configuration
- LL_ARB_WDOG_EN defined:
  - A counter of width $clog2(WDOG_CYCLES+1) clears on rq_accept and increments each cycle in ISSUE or BUSY.
  - When the counter equals WDOG_CYCLES: pulse rq_done[idx] with rq_err=1, advance rr_ptr, and go to IDLE.
  - If the watchdog expiry and a completion input occur in the same cycle, the completion takes precedence and its own rq_err rule applies.
- LL_ARB_WDOG_EN undefined: no counter exists, WDOG_CYCLES is unused, and a request can stay in ISSUE or BUSY indefinitely.

## Structure
- Shared package, next to t_mainop_types and t_specifier_types:
  - t_ll_arb_st enum: IDLE=0, ISSUE=1, BUSY=2.
  - Width constants HEADPTR_ADDR_WIDTH, NODENUM_WIDTH and DATA_WIDTH.
- One sub-module, ll_rr_pick: combinational. Takes NUM_REQ request bits and rr_ptr; returns a found flag and the granted index.

## Test plan
- Single requester: rq_vld=0001 with INSERT/AT_HEAD, ll_num=2, data=0xA5; dec_intf_ready=1 -> rq_accept=0001 one cycle later and dec fields equal the inputs; resp_gen_cmpltd -> rq_done=0001, rq_err=0.
- Fairness: all four rq_vld held high continuously -> grant order 0,1,2,3,0; rq_accept never grants the same index twice in a row.
- Field hold: change rq_data[0] to 0xFF after rq_accept -> dec_data stays 0xA5 until rq_done.
- Decode error: CONFIG_HDPTR with an invalid spec, then resp_gen_decode_err=1 -> rq_done[idx]=1, rq_err=1, next grant goes to idx+1.
- Back-pressure: ll_mngr_fsm_idle=0 for 20 cycles -> dec_req_vld stays high and the state stays ISSUE; when it goes high, the state moves to BUSY on the next edge.
- Watchdog, with LL_ARB_WDOG_EN and WDOG_CYCLES=15: no completion -> rq_done with rq_err=1 exactly 15 cycles after entering ISSUE. Also assert reset_n mid-BUSY -> all outputs 0 and no rq_done.
